reg_write_queue: RTL and testbench
==================================

Name: reg_write_queue

Overview:
Write-request buffer that sits directly downstream of the register-write strobe logic. Each rising edge of the incoming write strobe captures one address/data pair into a small FIFO. The FIFO is drained to the target register slave over a valid/ready handshake. This decouples bursty bus writes from a slower register target and flags any writes that are dropped.

Parameters:
ADDR_W, 8, width of the register address field
DATA_W, 32, width of the register data field
DEPTH, 4, FIFO entries; power of two, minimum 2

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  asynchronous, active-high reset
wr_strobe  in  1  write strobe, synchronous to clk; each low-to-high transition is one write
wr_addr  in  ADDR_W  write address, sampled on the capture cycle
wr_data  in  DATA_W  write data, sampled on the capture cycle
out_valid  out  1  head entry is available
out_ready  in  1  target accepts the head entry
out_addr  out  ADDR_W  head entry address
out_data  out  DATA_W  head entry data
full  out  1  count == DEPTH
empty  out  1  count == 0
count  out  $clog2(DEPTH+1)  number of occupied entries
overflow  out  1  sticky: a write was dropped
ovf_clr  in  1  clears overflow

Behaviour:
- Reset (asynchronous, active-high):
  - count=0, empty=1, full=0, out_valid=0, overflow=0.
  - Read and write pointers = 0; strobe-history flop = 0.
  - out_addr and out_data read as 0.
  - Reset asserted mid-operation discards all entries immediately, with no clock needed.
- Edge detect: strobe_d <= wr_strobe every cycle. push = wr_strobe & ~strobe_d.
  - A strobe held high for N cycles produces exactly one push.
  - A strobe already high when reset releases does not push. It must go low and then high again.
- Push: wr_addr and wr_data are written at wptr on the push cycle; wptr increments modulo DEPTH.
- Pop: pop = out_valid & out_ready. rptr increments modulo DEPTH.
- out_valid = ~empty, registered through count.
  - A push into an empty FIFO gives out_valid=1 on the following cycle (latency 1).
  - There is no combinational bypass.
- out_addr and out_data show the entry at rptr. They are stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop:
  - When not full: count unchanged, both pointers advance.
  - When full: the pop frees a slot, so the push is accepted and count stays at DEPTH.
  - When empty: only the push applies, because pop is impossible with out_valid=0.
- Overflow: push while full and no pop in the same cycle.
  - The entry is dropped; pointers and count are unchanged.
  - overflow <= 1 on the next edge.
- ovf_clr: overflow <= 0. If a clear and a new overflow event coincide, set wins.
- Count arithmetic:
  - count <= count + push_acc - pop.
  - Never exceeds DEPTH and never underflows.
  - full and empty are derived from count, not from pointer compare.
- out_ready while empty is ignored.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release -> count=0, empty=1, out_valid=0, overflow=0. Asserting rst asynchronously between edges clears the outputs immediately.
- Single write: strobe high for 3 cycles with addr=0x12, data=0xDEADBEEF, out_ready=0 -> count=1 one cycle after the rising edge, out_valid=1, head=0x12/0xDEADBEEF. Pulse out_ready for 1 cycle -> empty=1.
- Fill and overflow (DEPTH=4, out_ready=0):
  - Five separate strobes with data 1..5 -> full=1, count=4, overflow=1.
  - Draining yields 1,2,3,4 in order; entry 5 is absent.
  - ovf_clr -> overflow=0.
- Push and pop while full: FIFO full with 1..4, out_ready=1 and a strobe rising edge with data 9 in the same cycle -> count stays 4. Subsequent drain order is 2,3,4,9.
- Back-to-back throughput: strobe toggles every other cycle with data 0xA0..0xA7, out_ready=1 constantly -> all 8 appear in order, count never exceeds 1, overflow stays 0.
- Pointer wrap-around: 10 write/drain pairs with DEPTH=4 -> pointers wrap twice, data order is preserved, count returns to 0.

Source files
------------

// File: rtl/reg_write_queue.sv
// Write-request buffer: each rising edge of wr_strobe captures one addr/data pair
// into a small FIFO that drains over a valid/ready handshake; dropped writes set a sticky flag.
module reg_write_queue #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_strobe,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [DATA_W-1:0]          out_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  input  logic                       ovf_clr
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] r_mem_addr [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_strobe_d;
  logic              r_armed;
  logic              r_overflow;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_push_acc;
  logic w_drop;

  // A strobe still high after reset must first be seen low before it can push.
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_empty    = (r_count == CNT_W'(0));
  assign w_push     = wr_strobe & ~r_strobe_d & r_armed;
  assign w_pop      = ~w_empty & out_ready;
  assign w_push_acc = w_push & (~w_full | w_pop);
  assign w_drop     = w_push & w_full & ~w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_strobe_d <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_strobe_d <= wr_strobe;
      r_armed    <= r_armed | ~wr_strobe;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem_addr[i] <= '0;
        r_mem_data[i] <= '0;
      end
      r_wptr <= '0;
    end else if (w_push_acc) begin
      r_mem_addr[r_wptr] <= wr_addr;
      r_mem_data[r_wptr] <= wr_data;
      r_wptr             <= r_wptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push_acc, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Set has priority over clear when both land in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_overflow <= 1'b0;
    else if (w_drop)  r_overflow <= 1'b1;
    else if (ovf_clr) r_overflow <= 1'b0;
  end

  assign out_valid = ~w_empty;
  assign out_addr  = r_mem_addr[r_rptr];
  assign out_data  = r_mem_data[r_rptr];
  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_count;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_reg_write_queue.sv
// Directed bench for reg_write_queue: vector table plus hand-written multi-cycle sequences.
module tb_reg_write_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_strobe;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_addr;
  logic [31:0] out_data;
  logic        full;
  logic        empty;
  logic [2:0]  count;
  logic        overflow;
  logic        ovf_clr;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reg_write_queue #(.ADDR_W(8), .DATA_W(32), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  typedef struct {
    logic        s;
    logic [7:0]  a;
    logic [31:0] d;
    logic        rdy;
    logic        clr;
    logic [2:0]  cnt;
    logic        ovf;
    logic        hchk;
    logic [7:0]  haddr;
    logic [31:0] hdata;
  } vec_t;

  vec_t tv [23];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [2:0] cnt, input logic ovf);
    chk({tag, "_count"}, 64'(count), 64'(cnt));
    chk({tag, "_valid"}, 64'(out_valid), 64'(cnt != 3'd0));
    chk({tag, "_empty"}, 64'(empty), 64'(cnt == 3'd0));
    chk({tag, "_full"}, 64'(full), 64'(cnt == 3'd4));
    chk({tag, "_ovf"}, 64'(overflow), 64'(ovf));
  endtask

  initial begin
    int got;

    //      s     a      d             rdy   clr   cnt   ovf   hchk  haddr  hdata
    tv[0]  = '{1'b1, 8'h12, 32'hDEADBEEF, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 8'h12, 32'hDEADBEEF};
    tv[1]  = '{1'b1, 8'h12, 32'hDEADBEEF, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 8'h12, 32'hDEADBEEF};
    tv[2]  = '{1'b1, 8'h12, 32'hDEADBEEF, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 8'h12, 32'hDEADBEEF};
    tv[3]  = '{1'b0, 8'h00, 32'h0,        1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 32'h0};
    tv[4]  = '{1'b1, 8'h01, 32'h1,        1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 8'h01, 32'h1};
    tv[5]  = '{1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 8'h01, 32'h1};
    tv[6]  = '{1'b1, 8'h02, 32'h2,        1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 8'h01, 32'h1};
    tv[7]  = '{1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 8'h01, 32'h1};
    tv[8]  = '{1'b1, 8'h03, 32'h3,        1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 8'h01, 32'h1};
    tv[9]  = '{1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 8'h01, 32'h1};
    tv[10] = '{1'b1, 8'h04, 32'h4,        1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 8'h01, 32'h1};
    tv[11] = '{1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 8'h01, 32'h1};
    tv[12] = '{1'b1, 8'h05, 32'h5,        1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 8'h01, 32'h1};
    tv[13] = '{1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 8'h01, 32'h1};
    tv[14] = '{1'b0, 8'h00, 32'h0,        1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 8'h01, 32'h1};
    tv[15] = '{1'b1, 8'h07, 32'h7,        1'b0, 1'b1, 3'd4, 1'b1, 1'b1, 8'h01, 32'h1};
    tv[16] = '{1'b0, 8'h00, 32'h0,        1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 8'h01, 32'h1};
    tv[17] = '{1'b1, 8'h09, 32'h9,        1'b1, 1'b0, 3'd4, 1'b0, 1'b1, 8'h02, 32'h2};
    tv[18] = '{1'b0, 8'h00, 32'h0,        1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 8'h03, 32'h3};
    tv[19] = '{1'b0, 8'h00, 32'h0,        1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 8'h04, 32'h4};
    tv[20] = '{1'b0, 8'h00, 32'h0,        1'b1, 1'b0, 3'd1, 1'b0, 1'b1, 8'h09, 32'h9};
    tv[21] = '{1'b0, 8'h00, 32'h0,        1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 32'h0};
    tv[22] = '{1'b0, 8'h00, 32'h0,        1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 32'h0};

    rst = 1'b1; wr_strobe = 1'b0; wr_addr = '0; wr_data = '0; out_ready = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_state("reset", 3'd0, 1'b0);
    chk("reset_addr", 64'(out_addr), 64'h0);
    chk("reset_data", 64'(out_data), 64'h0);

    // Table: single write, fill/overflow, set-vs-clear, push+pop while full, drain
    for (int i = 0; i < 23; i++) begin
      wr_strobe = tv[i].s; wr_addr = tv[i].a; wr_data = tv[i].d;
      out_ready = tv[i].rdy; ovf_clr = tv[i].clr;
      @(negedge clk);
      chk_state($sformatf("vec%0d", i), tv[i].cnt, tv[i].ovf);
      if (tv[i].hchk) begin
        chk($sformatf("vec%0d_addr", i), 64'(out_addr), 64'(tv[i].haddr));
        chk($sformatf("vec%0d_data", i), 64'(out_data), 64'(tv[i].hdata));
      end
    end
    out_ready = 1'b0; ovf_clr = 1'b0;

    // Strobe held high across reset release must not push
    wr_strobe = 1'b1; wr_addr = 8'h33; wr_data = 32'h33;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_state("held_strobe", 3'd0, 1'b0);
    wr_strobe = 1'b0;
    @(negedge clk);
    wr_strobe = 1'b1;
    @(negedge clk);
    chk_state("rearm_push", 3'd1, 1'b0);
    chk("rearm_data", 64'(out_data), 64'h33);
    wr_strobe = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk_state("rearm_drain", 3'd0, 1'b0);

    // Back-to-back throughput with out_ready held high
    got = 0;
    for (int i = 0; i < 8; i++) begin
      for (int ph = 0; ph < 2; ph++) begin
        wr_strobe = (ph == 0); wr_addr = 8'(i); wr_data = 32'hA0 + 32'(i);
        @(negedge clk);
        chk("tp_count_le1", 64'(count <= 3'd1), 64'h1);
        chk("tp_ovf", 64'(overflow), 64'h0);
        if (out_valid) begin
          chk("tp_data", 64'(out_data), 64'(32'hA0 + 32'(got)));
          got++;
        end
      end
    end
    chk("tp_total", 64'(got), 64'd8);
    out_ready = 1'b0;

    // Ten write/drain pairs wrap both pointers
    for (int i = 0; i < 10; i++) begin
      wr_strobe = 1'b1; wr_addr = 8'(8'h40 + i); wr_data = 32'h100 + 32'(i);
      @(negedge clk);
      chk("wrap_valid", 64'(out_valid), 64'h1);
      chk("wrap_addr", 64'(out_addr), 64'(8'h40 + i));
      chk("wrap_data", 64'(out_data), 64'(32'h100 + 32'(i)));
      wr_strobe = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("wrap_count", 64'(count), 64'h0);
      out_ready = 1'b0;
    end

    // Asynchronous reset between edges clears state without a clock
    for (int i = 0; i < 2; i++) begin
      wr_strobe = 1'b1; wr_addr = 8'hC0; wr_data = 32'hC0DE;
      @(negedge clk);
      wr_strobe = 1'b0;
      @(negedge clk);
    end
    chk("async_pre_count", 64'(count), 64'd2);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk_state("async_rst", 3'd0, 1'b0);
    chk("async_addr", 64'(out_addr), 64'h0);
    chk("async_data", 64'(out_data), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
